// File: rtl/ifetch_pkg.sv
// Shared fetch-front-end constants and FSM state encoding.
package ifetch_pkg;
  localparam int          IF_ADDR_W    = 16;
  localparam int          IF_INSTR_W   = 16;
  localparam logic [15:0] IF_RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } state_e;
endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port and decode hand-off port of the fetch unit.
interface ifetch_imem_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = IF_ADDR_W,
  parameter int INSTR_W = IF_INSTR_W
) ();
  logic               imem_re;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_vld;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_re, imem_addr, input imem_vld, imem_rdata);
  modport slave  (input imem_re, imem_addr, output imem_vld, imem_rdata);
endinterface

interface ifetch_dec_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = IF_ADDR_W,
  parameter int INSTR_W = IF_INSTR_W
) ();
  logic               instr_vld;
  logic               instr_rdy;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (output instr_vld, instr, instr_pc, input instr_rdy);
  modport slave  (input instr_vld, instr, instr_pc, output instr_rdy);
endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry circular buffer of {pc, instr}; flush empties it in one cycle.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (pop) rd_ptr_d = nxt(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/ifetch_unit.sv
// Fetch PC, single-outstanding read FSM with kill, queue to decode, redirect and halt.
// IFETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W    = IF_ADDR_W,
  parameter int                INSTR_W   = IF_INSTR_W,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(IF_RESET_VEC)
) (
  input  logic                clk,
  input  logic                rst_n,
  ifetch_imem_if.master       imem,
  ifetch_dec_if.master        dec,
  input  logic                redir,
  input  logic [ADDR_W-1:0]   redir_addr,
  input  logic                hlt,
  output logic                halted
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = ADDR_W + INSTR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d;
  logic              issue, resp, push, pop, byp, empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic [ENT_W-1:0]  head;

  assign resp = (state_q == ST_WAIT) && imem.imem_vld;
  // Queue slots already promised: stored entries plus the read in flight.
  assign occ  = {1'b0, count} + {{CNT_W{1'b0}}, (state_q == ST_WAIT)};
  assign issue = rst_n && ((state_q == ST_RUN) || resp) && !hlt && !redir
                 && (occ < (CNT_W+1)'(DEPTH));

`ifdef IFETCH_BYPASS_EN
  assign byp = rst_n && resp && empty && !redir;
`else
  assign byp = 1'b0;
`endif

  assign dec.instr_vld = rst_n && (byp || !empty);
  assign dec.instr     = byp ? imem.imem_rdata : head[INSTR_W-1:0];
  assign dec.instr_pc  = byp ? pend_pc_q : head[ENT_W-1:INSTR_W];
  assign push = resp && !redir && !(byp && dec.instr_rdy);
  assign pop  = dec.instr_vld && dec.instr_rdy && !byp;

  assign imem.imem_re   = issue;
  assign imem.imem_addr = fetch_pc_q;
  assign halted         = hlt && (state_q == ST_RUN);

  ifetch_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redir),
    .push  (push),
    .pop   (pop),
    .wdata ({pend_pc_q, imem.imem_rdata}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    if (redir) begin
      fetch_pc_d = redir_addr;
      case (state_q)
        ST_WAIT, ST_KILL: state_d = imem.imem_vld ? ST_RUN : ST_KILL;
        default:          state_d = ST_RUN;
      endcase
    end else begin
      case (state_q)
        ST_RUN:  if (issue) state_d = ST_WAIT;
        ST_WAIT: if (imem.imem_vld) state_d = issue ? ST_WAIT : ST_RUN;
        ST_KILL: if (imem.imem_vld) state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
      if (issue) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_VEC;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: variable-latency memory model, read/pop logs, hand-computed expectations.
module tb_ifetch_unit;
`ifdef IFETCH_BYPASS_EN
  localparam int LATX = 1;
`else
  localparam int LATX = 2;
`endif

  logic        clk = 1'b0, rst_n, redir, hlt, halted, halted2;
  logic [15:0] redir_addr;
  int          total = 0, bad = 0, cyc = 0, lat = 1, m_cnt = 0;
  bit          m_busy = 0, found;
  logic [15:0] m_addr = '0, addr2q = '0;
  logic        pend2 = 1'b0;
  int          rd_addr[$], rd_cyc[$], pop_pc[$], pop_ins[$], pop_cyc[$];
  int          rd2[$], pop2_pc[$], pop2_ins[$];
  int          r0, rc, n;

  ifetch_imem_if #(.ADDR_W(16), .INSTR_W(16)) im  ();
  ifetch_dec_if  #(.ADDR_W(16), .INSTR_W(16)) dc  ();
  ifetch_imem_if #(.ADDR_W(16), .INSTR_W(16)) im2 ();
  ifetch_dec_if  #(.ADDR_W(16), .INSTR_W(16)) dc2 ();

  ifetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_VEC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem(im), .dec(dc),
    .redir(redir), .redir_addr(redir_addr), .hlt(hlt), .halted(halted));

  ifetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_VEC(16'hFFFE)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .imem(im2), .dec(dc2),
    .redir(1'b0), .redir_addr(16'h0000), .hlt(1'b0), .halted(halted2));

  always #5 clk = ~clk;

  // Memory models and monitors: drive responses at negedge, sample requests/pops 3 later.
  always @(negedge clk) begin
    cyc++;
    im.imem_vld = 1'b0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        im.imem_vld   = 1'b1;
        im.imem_rdata = m_addr ^ 16'hA5A5;
        m_busy        = 0;
      end
    end
    im2.imem_vld   = pend2;
    im2.imem_rdata = addr2q ^ 16'hA5A5;
    #3;
    if (im.imem_re) begin
      m_busy = 1; m_cnt = lat; m_addr = im.imem_addr;
      rd_addr.push_back(int'(im.imem_addr)); rd_cyc.push_back(cyc);
    end
    if (dc.instr_vld && dc.instr_rdy) begin
      pop_pc.push_back(int'(dc.instr_pc)); pop_ins.push_back(int'(dc.instr)); pop_cyc.push_back(cyc);
    end
    pend2 = im2.imem_re; addr2q = im2.imem_addr;
    if (im2.imem_re) rd2.push_back(int'(im2.imem_addr));
    if (dc2.instr_vld && dc2.instr_rdy) begin
      pop2_pc.push_back(int'(dc2.instr_pc)); pop2_ins.push_back(int'(dc2.instr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redir = 1'b0; hlt = 1'b0;
    repeat (4) tick();
    chk("rst_re", im.imem_re, 0);
    chk("rst_vld", dc.instr_vld, 0);
    chk("rst_halted", halted, 0);
    rd_addr.delete(); rd_cyc.delete(); pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    rd2.delete(); pop2_pc.delete(); pop2_ins.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redir = 1'b0; hlt = 1'b0; redir_addr = '0;
    dc.instr_rdy = 1'b1; dc2.instr_rdy = 1'b1;

    // 1: streaming, 1-cycle memory
    lat = 1; do_reset();
    repeat (14) tick();
    r0 = qat(rd_cyc, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_rd%0d", i), qat(rd_addr, i), i);
      chk($sformatf("t1_rdcyc%0d", i), qat(rd_cyc, i) - r0, i);
      chk($sformatf("t1_pc%0d", i), qat(pop_pc, i), i);
      chk($sformatf("t1_ins%0d", i), qat(pop_ins, i), i ^ 32'hA5A5);
      chk($sformatf("t1_lat%0d", i), qat(pop_cyc, i) - r0, LATX + i);
    end
    chk("t6_wrap0", qat(rd2, 0), 32'hFFFE);
    chk("t6_wrap1", qat(rd2, 1), 32'hFFFF);
    chk("t6_wrap2", qat(rd2, 2), 32'h0000);
    chk("t6_pop_pc", qat(pop2_pc, 0), 32'hFFFE);
    chk("t6_pop_ins", qat(pop2_ins, 0), 32'hFFFE ^ 32'hA5A5);
    chk("t6_halted2", halted2, 0);

    // 2: decode stalled, queue fills to DEPTH
    dc.instr_rdy = 1'b0; do_reset();
    repeat (10) tick();
    chk("t2_nreads", rd_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_rd%0d", i), qat(rd_addr, i), i);
    chk("t2_re_idle", im.imem_re, 0);
    chk("t2_count", u_dut.u_fifo.count_q, 4);
    chk("t2_head_vld", dc.instr_vld, 1);
    chk("t2_head_pc", dc.instr_pc, 0);
    dc.instr_rdy = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) chk($sformatf("t2_pop%0d", i), qat(pop_pc, i), i);
    chk("t2_resume", qat(rd_addr, 4), 4);

    // 3: redirect while a 3-cycle read is in flight
    lat = 3; do_reset();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (im.imem_re && im.imem_addr == 16'h0005) found = 1;
    end
    chk("t3_found", found, 1);
    tick(); redir = 1'b1; redir_addr = 16'h0040;
    tick(); redir = 1'b0;
    repeat (12) tick();
    chk("t3_rd5", qat(rd_addr, 5), 5);
    chk("t3_rd_new", qat(rd_addr, 6), 32'h40);
    chk("t3_kill_gap", qat(rd_cyc, 6) - qat(rd_cyc, 5), 4);
    n = 0;
    foreach (pop_pc[i]) if (pop_pc[i] == 5) n++;
    chk("t3_no_stale", n, 0);
    chk("t3_pop_new", qat(pop_pc, 5), 32'h40);
    chk("t3_ins_new", qat(pop_ins, 5), 32'h40 ^ 32'hA5A5);
    chk("t3_pop_next", qat(pop_pc, 6), 32'h41);

    // 4: redirect in the same cycle as the response
    do_reset();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (im.imem_vld && im.imem_rdata == (16'h0002 ^ 16'hA5A5)) found = 1;
    end
    chk("t4_found", found, 1);
    redir = 1'b1; redir_addr = 16'h0080; rc = cyc;
    tick(); redir = 1'b0;
    repeat (8) tick();
    chk("t4_rd_new", qat(rd_addr, 3), 32'h80);
    chk("t4_rd_when", qat(rd_cyc, 3) - rc, 1);
    chk("t4_pop_new", qat(pop_pc, 2), 32'h80);

    // 5: halt with a read outstanding
    dc.instr_rdy = 1'b0; do_reset();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (im.imem_re && im.imem_addr == 16'h0002) found = 1;
    end
    chk("t5_found", found, 1);
    tick(); hlt = 1'b1; #1;
    chk("t5_busy", halted, 0);
    for (int k = 0; k < 10 && !halted; k++) tick();
    chk("t5_halted", halted, 1);
    dc.instr_rdy = 1'b1;
    repeat (8) tick();
    chk("t5_nreads", rd_addr.size(), 3);
    chk("t5_npops", pop_pc.size(), 3);
    chk("t5_last_pop", qat(pop_pc, 2), 2);
    chk("t5_drained", dc.instr_vld, 0);
    chk("t5_still_halted", halted, 1);
    hlt = 1'b0; #1;
    chk("t5_resume_re", im.imem_re, 1);
    chk("t5_resume_addr", im.imem_addr, 3);
    tick();
    chk("t5_rd3", qat(rd_addr, 3), 3);

    // 6: reset in the middle of a read
    do_reset();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (im.imem_re && im.imem_addr == 16'h0001) found = 1;
    end
    chk("t6_found", found, 1);
    tick(); rst_n = 1'b0; hlt = 1'b1; #1;
    chk("t6_rst_re", im.imem_re, 0);
    chk("t6_rst_vld", dc.instr_vld, 0);
    tick(); rst_n = 1'b1;
    pop_pc.delete(); rd_addr.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t6_no_vld%0d", k), dc.instr_vld, 0);
    end
    chk("t6_no_pops", pop_pc.size(), 0);
    chk("t6_halted", halted, 1);
    hlt = 1'b0;
    tick();
    chk("t6_restart", qat(rd_addr, 0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
